// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared definitions for the UART transmit scheduler.
//   sched_state_e : scheduler FSM states
//   ACK_TO_DEF    : default cycles allowed for tx_busy to rise after tx_start
//   GAP_W_DEF     : default width of the inter-frame gap counter
//   wrap_inc()    : modulo-n increment used for the round-robin pointer
package uart_sched_pkg;

  localparam int unsigned ACK_TO_DEF = 16;
  localparam int unsigned GAP_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_GAP
  } sched_state_e;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if: requester-side and serializer-side handshake bundle.
//   req_valid/req_data/req_ready : per-requester byte handshake
//   tx_start/tx_data/tx_busy     : start/data/busy handshake with the UART TX core
// master : the scheduler (drives req_ready, tx_start, tx_data)
// slave  : requesters plus serializer (drive req_valid, req_data, tx_busy)
interface uart_tx_sched_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_start, tx_data
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_rr_arb.sv
// uart_rr_arb: combinational winner select among full holders.
//   full_i       : holder-full vector
//   ptr_i        : round-robin start index
//   fixed_prio_i : 1 = lowest full index wins, 0 = first full index at/after ptr_i (wrapping)
//   win_o        : winning index (0 when nothing is full)
//   any_o        : at least one holder is full
module uart_rr_arb
  import uart_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         full_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  input  logic                    fixed_prio_i,
  output logic [$clog2(NREQ)-1:0] win_o,
  output logic                    any_o
);
  localparam int unsigned IDX_W = $clog2(NREQ);

  always_comb begin : sel
    int unsigned idx;
    logic        found;
    win_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = fixed_prio_i ? k : ((32'(ptr_i) + k) % NREQ);
      if (!found && full_i[idx[IDX_W-1:0]]) begin
        win_o = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

  assign any_o = |full_i;

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART TX serializer among NREQ requesters.
// Each requester owns a one-deep holder; full holders are granted one at a
// time (round-robin or fixed priority), a start pulse is issued, and the
// serializer's busy handshake frames completion, followed by an optional gap.
//   mclk, reset      : clock, synchronous active-high reset
//   cfg_en           : enable new grants
//   cfg_fixed_prio   : 1 fixed priority, 0 round-robin
//   cfg_gap          : idle cycles after each frame
//   bus (master)     : req_valid/req_data/req_ready, tx_start/tx_data/tx_busy
//   grant_id         : current/last granted requester
//   sched_busy       : FSM not idle
//   err_ack_to       : sticky serializer acknowledge timeout
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned GAP_W  = GAP_W_DEF,
  parameter int unsigned ACK_TO = ACK_TO_DEF
) (
  input  logic                    mclk,
  input  logic                    reset,
  input  logic                    cfg_en,
  input  logic                    cfg_fixed_prio,
  input  logic [GAP_W-1:0]        cfg_gap,
  uart_tx_sched_if.master         bus,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    sched_busy,
  output logic                    err_ack_to
);
  localparam int unsigned IDX_W = $clog2(NREQ);
  localparam int unsigned ACK_W = $clog2(ACK_TO + 1);

  sched_state_e     state_q, state_d;
  logic [NREQ-1:0]  full_q, full_d;
  logic [NREQ-1:0]  rdy_q;
  logic [NREQ-1:0]  accept;
  logic [7:0]       hold_q [NREQ];
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] win;
  logic             any_full;
  logic [7:0]       txd_q, txd_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             err_q, err_d;

  // req_ready is its own register so it reads 0 throughout reset and
  // only rises on the first edge after reset is released.
  assign accept = bus.req_valid & rdy_q;

  uart_rr_arb #(.NREQ(NREQ)) u_arb (
    .full_i       (full_q),
    .ptr_i        (ptr_q),
    .fixed_prio_i (cfg_fixed_prio),
    .win_o        (win),
    .any_o        (any_full)
  );

  // Holder occupancy: set on accept, cleared at the end of ISSUE.
  always_comb begin
    full_d = full_q;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (accept[i]) begin
        full_d[i] = 1'b1;
      end else if (state_q == ST_ISSUE && grant_q == IDX_W'(i)) begin
        full_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) hold_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (accept[i]) hold_q[i] <= bus.req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    txd_d     = txd_q;
    ptr_d     = ptr_q;
    ack_cnt_d = ack_cnt_q;
    gap_cnt_d = gap_cnt_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_en && any_full) begin
          grant_d = win;
          txd_d   = hold_q[win];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ptr_d     = IDX_W'(wrap_inc(32'(grant_q), NREQ));
        ack_cnt_d = '0;
        state_d   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // ack_cnt_q holds the number of WAIT_ACK cycles already spent
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q == ACK_W'(ACK_TO - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + ACK_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (cfg_gap != '0) begin
            gap_cnt_d = cfg_gap;
            state_d   = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      full_q    <= '0;
      rdy_q     <= '0;
      grant_q   <= '0;
      ptr_q     <= '0;
      txd_q     <= '0;
      ack_cnt_q <= '0;
      gap_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      full_q    <= full_d;
      rdy_q     <= ~full_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      txd_q     <= txd_d;
      ack_cnt_q <= ack_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.tx_start  = (state_q == ST_ISSUE);
  assign bus.tx_data   = txd_q;
  assign grant_id      = grant_q;
  assign sched_busy    = (state_q != ST_IDLE);
  assign err_ack_to    = err_q;

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmit serializer among NREQ byte-stream requesters (debug console, boot loader, BIST reporter, user port). Each requester owns a one-deep holding register. The scheduler grants one full holder at a time, issues a start pulse to the serializer, and tracks the serializer's busy handshake to frame completion. An optional inter-frame gap follows each frame. It sits between the requester logic and the UART TX core in the peripheral subsystem.

## Interface
- NREQ, 4, number of requesters (2..8)
- GAP_W, 16, width of inter-frame gap counter
- ACK_TO, 16, cycles allowed for tx_busy to rise after tx_start
- Clocking/reset: one clock; reset is synchronous and active-high.
- mclk  in  1  system clock
- reset  in  1  synchronous active-high reset
- cfg_en  in  1  scheduler enable; low blocks new grants
- cfg_fixed_prio  in  1  1: fixed priority (lowest index wins), 0: round-robin
- cfg_gap  in  GAP_W  idle mclk cycles inserted after each frame (0 = none)
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  NREQ*8  packed bytes, requester i at [8i+7:8i]
- req_ready  out  NREQ  holder i empty
- tx_start  out  1  one-cycle start pulse to serializer
- tx_data  out  8  byte to serializer, stable from tx_start until frame done
- tx_busy  in  1  serializer busy (high for the whole frame)
- grant_id  out  $clog2(NREQ)  index of the current/last granted requester
- sched_busy  out  1  FSM not in IDLE
- err_ack_to  out  1  sticky: serializer failed to acknowledge a start

## Operation
- Holder i loads on req_valid[i] & req_ready[i]; full[i] set next edge. req_ready[i] = ~full[i] (registered, no same-cycle bypass). Data in a full holder is frozen.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP.
- IDLE: if cfg_en and |full, select the winner, register grant_id and tx_data, go to ISSUE. Otherwise stay in IDLE.
- Winner selection:
  - Round-robin: first full index at or after ptr, wrapping NREQ-1 -> 0.
  - Fixed priority: lowest full index.
- ISSUE: tx_start=1 for exactly this cycle. Clear full[grant_id] at the end of the cycle. ptr <= grant_id+1 mod NREQ. Go to WAIT_ACK.
- WAIT_ACK: on tx_busy=1 go to WAIT_DONE. If ACK_TO cycles elapse first, set err_ack_to and go to IDLE (the byte is dropped).
- WAIT_DONE: on tx_busy=0 go to GAP if cfg_gap!=0, else go to IDLE.
- GAP: count cfg_gap cycles (value sampled on GAP entry), then go to IDLE.
- cfg_en low mid-frame: the current frame and gap complete, then the FSM holds in IDLE. Holders keep accepting until full.
- err_ack_to clears only on reset.

## Timing
- Reset values: req_ready=0 during reset, all 1 the cycle after; tx_start=0, tx_data=0, grant_id=0, sched_busy=0, err_ack_to=0; ptr=0; all holders empty; FSM in IDLE.
- Latency from accept edge N: full visible in cycle N+1, tx_start high in cycle N+2 (scheduler idle, cfg_en=1).
- Holder i reloads no earlier than the cycle after ISSUE (req_ready[i] rises the cycle after ISSUE).
- Back-to-back with cfg_gap=0: the next ISSUE comes 2 cycles after tx_busy falls (one cycle in IDLE).
- tx_busy already high in ISSUE is ignored; it is sampled only in WAIT_ACK and WAIT_DONE.
- The ACK timeout counter counts WAIT_ACK cycles. The timeout fires on the ACK_TO-th cycle.
- Reset mid-frame aborts immediately: tx_start is low, and holder contents are discarded.

## Structure
- Shared package uart_sched_pkg: FSM state enum, ACK_TO default, GAP_W default.
- One sub-module, uart_rr_arb: purely combinational winner select (inputs full vector, ptr, fixed-prio mode; outputs winner index and any-valid). It is instantiated once. The FSM, holders and counters live in uart_tx_sched.

## Test plan
- Single byte: req 2 sends 0xA5; model busy for 10 cycles after start -> tx_start in cycle N+2, tx_data=0xA5, grant_id=2, req_ready[2] rises the cycle after ISSUE.
- Round-robin: all 4 holders full (0x10..0x13), ptr=0, cfg_gap=0 -> grant order 0,1,2,3. Refill holder 0 after its grant -> it is served after 3.
- Fixed priority: cfg_fixed_prio=1, holders 1 and 3 full; refill 1 after each frame -> 1 is served every time, 3 starves until 1 stops.
- Gap: cfg_gap=5, two queued bytes -> exactly 5 + 1 idle cycles between busy falling and the second tx_start.
- Ack timeout: tx_busy tied 0 -> err_ack_to set ACK_TO cycles after tx_start, FSM returns to IDLE, and the next full holder is issued.
- cfg_en drop mid-frame, then reset during WAIT_DONE -> the frame completes with no new grant; on reset all outputs return to reset values the next cycle.
